pipe_elastic_buf: RTL and testbench

- Parametrised, multi-entry elastic pipeline buffer with a valid/ready handshake on both sides.
- Replaces the fixed single-entry inter-stage registers (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Adds configurable width and depth, full-throughput operation at depth >= 2, synchronous flush for branch redirect, and a saturating stall counter for performance measurement.
- Sits between any two stages; the payload is an opaque packed word carrying pc, instruction, control word, etc.

---
 rtl/pipe_types.sv | 77 +++++++
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_elastic_buf.sv | 114 +++++++++++
 tb/tb_pipe_elastic_buf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_types.sv
// Shared defaults and stage-boundary payload types for the elastic pipeline buffers.
package pipe_types;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 2;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [4:0]      reg_idx_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef struct packed {
    alu_op_t  alu_op;
    logic     alu_src_imm;
    logic     mem_read;
    logic     mem_write;
    logic [2:0] funct3;
    logic     reg_write;
    wb_sel_t  wb_sel;
    reg_idx_t rd;
    logic     branch;
    logic     jump;
  } control_word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fet_dec_t;

  typedef struct packed {
    word_t         pc;
    control_word_t ctrl;
    word_t         rs1_val;
    word_t         rs2_val;
    word_t         imm;
  } dec_exe_t;

  typedef struct packed {
    word_t         pc;
    control_word_t ctrl;
    word_t         alu_res;
    word_t         store_data;
  } exe_mem_t;

  typedef struct packed {
    word_t         pc;
    control_word_t ctrl;
    word_t         wb_data;
  } mem_wb_t;

  // DATA_W to use when instantiating a buffer at each stage boundary.
  localparam int unsigned FET_DEC_W = $bits(fet_dec_t);
  localparam int unsigned DEC_EXE_W = $bits(dec_exe_t);
  localparam int unsigned EXE_MEM_W = $bits(exe_mem_t);
  localparam int unsigned MEM_WB_W  = $bits(mem_wb_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
  import pipe_types::*;
#(
  parameter int unsigned WIDTH = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_elastic_buf.sv
// Multi-entry valid/ready elastic buffer between pipeline stages, with flush
// and a saturating stall counter. All handshake flags are registered.
module pipe_elastic_buf
  import pipe_types::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_data_d;
  logic              push, pop;

  // Wraps at DEPTH-1 so non-power-of-two depths cycle correctly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers/occupancy and the payload that will sit at the head.
  always_comb begin
    push        = valid_i & ready_o & ~flush;
    pop         = valid_o & ready_i & ~flush;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    head_data_d = '0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = next_ptr(tail_q);
      if (pop)  head_d = next_ptr(head_q);
      if (push && !pop) begin
        count_d = count_q + OCC_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - OCC_W'(1);
      end
    end
    // A push landing in the slot that becomes the head is forwarded into data_o.
    if (count_d != '0) begin
      head_data_d = (push && (tail_q == head_d)) ? data_i : mem_q[head_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q] <= data_i;
      data_o  <= head_data_d;
      valid_o <= (count_d != '0);
      ready_o <= (count_d != FULL_CNT);
      full_o  <= (count_d == FULL_CNT);
      empty_o <= (count_d == '0);
    end
  end

  assign count_o = count_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (valid_o & ~ready_i & ~flush),
    .clr   (1'b0),
    .count (stall_cnt_o)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    count_q <= FULL_CNT);
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
    pop |-> (count_q != '0));
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst)
    push |-> (count_q != FULL_CNT));
  a_head_stable : assert property (@(posedge clk) disable iff (!rst)
    (valid_o && !ready_i && !flush) |=> $stable(data_o));

endmodule

// File: tb/tb_pipe_elastic_buf.sv
// Directed bench for pipe_elastic_buf at several depths and counter widths.
module tb_pipe_elastic_buf;

  localparam int unsigned DW = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic          d2_flush, d2_vi, d2_ro, d2_vo, d2_ri, d2_full, d2_empty;
  logic [DW-1:0] d2_di, d2_do;
  logic [1:0]    d2_cnt;
  logic [15:0]   d2_stall;

  logic          d1_flush, d1_vi, d1_ro, d1_vo, d1_ri, d1_full, d1_empty;
  logic [DW-1:0] d1_di, d1_do;
  logic [0:0]    d1_cnt;
  logic [15:0]   d1_stall;

  logic          d3_flush, d3_vi, d3_ro, d3_vo, d3_ri, d3_full, d3_empty;
  logic [DW-1:0] d3_di, d3_do;
  logic [1:0]    d3_cnt;
  logic [15:0]   d3_stall;

  logic          c4_flush, c4_vi, c4_ro, c4_vo, c4_ri, c4_full, c4_empty;
  logic [DW-1:0] c4_di, c4_do;
  logic [1:0]    c4_cnt;
  logic [3:0]    c4_stall;

  pipe_elastic_buf #(.DATA_W(DW), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .flush(d2_flush), .valid_i(d2_vi), .ready_o(d2_ro),
    .data_i(d2_di), .valid_o(d2_vo), .ready_i(d2_ri), .data_o(d2_do),
    .count_o(d2_cnt), .full_o(d2_full), .empty_o(d2_empty), .stall_cnt_o(d2_stall));

  pipe_elastic_buf #(.DATA_W(DW), .DEPTH(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .flush(d1_flush), .valid_i(d1_vi), .ready_o(d1_ro),
    .data_i(d1_di), .valid_o(d1_vo), .ready_i(d1_ri), .data_o(d1_do),
    .count_o(d1_cnt), .full_o(d1_full), .empty_o(d1_empty), .stall_cnt_o(d1_stall));

  pipe_elastic_buf #(.DATA_W(DW), .DEPTH(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .flush(d3_flush), .valid_i(d3_vi), .ready_o(d3_ro),
    .data_i(d3_di), .valid_o(d3_vo), .ready_i(d3_ri), .data_o(d3_do),
    .count_o(d3_cnt), .full_o(d3_full), .empty_o(d3_empty), .stall_cnt_o(d3_stall));

  pipe_elastic_buf #(.DATA_W(DW), .DEPTH(2), .CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .flush(c4_flush), .valid_i(c4_vi), .ready_o(c4_ro),
    .data_i(c4_di), .valid_o(c4_vo), .ready_i(c4_ri), .data_o(c4_do),
    .count_o(c4_cnt), .full_o(c4_full), .empty_o(c4_empty), .stall_cnt_o(c4_stall));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    d2_flush = 0; d2_vi = 0; d2_ri = 0; d2_di = '0;
    d1_flush = 0; d1_vi = 0; d1_ri = 0; d1_di = '0;
    d3_flush = 0; d3_vi = 0; d3_ri = 0; d3_di = '0;
    c4_flush = 0; c4_vi = 0; c4_ri = 0; c4_di = '0;
    #1 rst = 1'b0;
    #1;

    // Reset values
    chk("rst_valid", 32'(d2_vo), 32'd0);
    chk("rst_ready", 32'(d2_ro), 32'd1);
    chk("rst_count", 32'(d2_cnt), 32'd0);
    chk("rst_data", 32'(d2_do), 32'd0);
    chk("rst_stall", 32'(d2_stall), 32'd0);
    chk("rst_full", 32'(d2_full), 32'd0);
    chk("rst_empty", 32'(d2_empty), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("idle_ready", 32'(d2_ro), 32'd1);
    chk("idle_valid", 32'(d2_vo), 32'd0);

    // Fill DEPTH=2 with downstream stalled
    d2_vi = 1; d2_ri = 0; d2_di = 8'h0A;
    tick();
    chk("fill1_count", 32'(d2_cnt), 32'd1);
    chk("fill1_data", 32'(d2_do), 32'h0A);
    chk("fill1_ready", 32'(d2_ro), 32'd1);
    chk("fill1_stall", 32'(d2_stall), 32'd0);
    d2_di = 8'h0B;
    tick();
    chk("fill2_full", 32'(d2_full), 32'd1);
    chk("fill2_ready", 32'(d2_ro), 32'd0);
    chk("fill2_data", 32'(d2_do), 32'h0A);
    chk("fill2_stall", 32'(d2_stall), 32'd1);
    d2_di = 8'h0C;
    tick();
    chk("fill3_count", 32'(d2_cnt), 32'd2);
    chk("fill3_data", 32'(d2_do), 32'h0A);
    chk("fill3_stall", 32'(d2_stall), 32'd2);
    d2_vi = 0; d2_ri = 1;
    tick();
    chk("drain1_data", 32'(d2_do), 32'h0B);
    chk("drain1_ready", 32'(d2_ro), 32'd1);
    chk("drain1_stall", 32'(d2_stall), 32'd2);
    tick();
    chk("drain2_valid", 32'(d2_vo), 32'd0);
    chk("drain2_data", 32'(d2_do), 32'd0);
    chk("drain2_empty", 32'(d2_empty), 32'd1);

    // Full-throughput stream on DEPTH=2
    d2_vi = 1; d2_ri = 1;
    for (int i = 1; i <= 100; i++) begin
      d2_di = DW'(i);
      tick();
      chk("stream_data", 32'(d2_do), 32'(i));
      chk("stream_count", 32'(d2_cnt), 32'd1);
    end
    d2_vi = 0;
    tick();
    chk("stream_end_empty", 32'(d2_empty), 32'd1);
    chk("stream_end_stall", 32'(d2_stall), 32'd2);

    // DEPTH=1 half-rate stream
    d1_vi = 1; d1_ri = 1;
    for (int t = 1; t <= 20; t++) begin
      d1_di = DW'((t + 1) / 2);
      tick();
      if ((t % 2) == 1) begin
        chk("d1_odd_valid", 32'(d1_vo), 32'd1);
        chk("d1_odd_data", 32'(d1_do), 32'((t + 1) / 2));
        chk("d1_odd_ready", 32'(d1_ro), 32'd0);
      end else begin
        chk("d1_even_valid", 32'(d1_vo), 32'd0);
        chk("d1_even_ready", 32'(d1_ro), 32'd1);
      end
    end
    d1_vi = 0;

    // DEPTH=3 fill, flush with an offered input, then wrap both pointers
    d3_vi = 1; d3_ri = 0; d3_di = 8'h11;
    tick();
    d3_di = 8'h22;
    tick();
    d3_di = 8'h33;
    tick();
    chk("d3_full", 32'(d3_full), 32'd1);
    chk("d3_count", 32'(d3_cnt), 32'd3);
    chk("d3_head", 32'(d3_do), 32'h11);
    chk("d3_stall_pre", 32'(d3_stall), 32'd2);
    d3_flush = 1; d3_di = 8'h44;
    tick();
    chk("flush_count", 32'(d3_cnt), 32'd0);
    chk("flush_valid", 32'(d3_vo), 32'd0);
    chk("flush_data", 32'(d3_do), 32'd0);
    chk("flush_ready", 32'(d3_ro), 32'd1);
    chk("flush_stall", 32'(d3_stall), 32'd2);
    d3_flush = 0; d3_di = 8'h55;
    tick();
    chk("post_flush_data", 32'(d3_do), 32'h55);
    chk("post_flush_count", 32'(d3_cnt), 32'd1);
    d3_di = 8'h66;
    tick();
    d3_di = 8'h77;
    tick();
    chk("refill_full", 32'(d3_full), 32'd1);
    chk("refill_head", 32'(d3_do), 32'h55);
    d3_di = 8'h88; d3_ri = 1;
    tick();
    chk("full_pop_data", 32'(d3_do), 32'h66);
    chk("full_pop_count", 32'(d3_cnt), 32'd2);
    chk("full_pop_ready", 32'(d3_ro), 32'd1);
    tick();
    chk("wrap_pp_data", 32'(d3_do), 32'h77);
    chk("wrap_pp_count", 32'(d3_cnt), 32'd2);
    d3_vi = 0;
    tick();
    chk("wrap_head_data", 32'(d3_do), 32'h88);
    chk("wrap_head_count", 32'(d3_cnt), 32'd1);
    tick();
    chk("wrap_end_empty", 32'(d3_empty), 32'd1);

    // CNT_W=4 stall counter saturation
    c4_vi = 1; c4_ri = 0; c4_di = 8'h5A;
    tick();
    chk("sat_start", 32'(c4_stall), 32'd0);
    c4_vi = 0;
    repeat (9) tick();
    chk("sat_mid", 32'(c4_stall), 32'd9);
    repeat (6) tick();
    chk("sat_top", 32'(c4_stall), 32'd15);
    repeat (5) tick();
    chk("sat_hold", 32'(c4_stall), 32'd15);
    chk("sat_data", 32'(c4_do), 32'h5A);
    chk("sat_count", 32'(c4_cnt), 32'd1);

    // Asynchronous reset between edges
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(c4_vo), 32'd0);
    chk("arst_ready", 32'(c4_ro), 32'd1);
    chk("arst_full", 32'(c4_full), 32'd0);
    chk("arst_empty", 32'(c4_empty), 32'd1);
    chk("arst_data", 32'(c4_do), 32'd0);
    chk("arst_count", 32'(c4_cnt), 32'd0);
    chk("arst_stall", 32'(c4_stall), 32'd0);
    chk("arst_d3_stall", 32'(d3_stall), 32'd0);
    #2 rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
